// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel prescaler, horizontal/vertical phase FSMs, sync/enable decode.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync/enable by one pixel to match a one-pixel-deep colour pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       enable,
  output logic [9:0] current_row,
  output logic [9:0] current_line,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last coordinate of each phase; the FSMs leave a phase on these values.
  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [3:0] DIV_LAST    = 4'(PIX_DIV - 1);

  typedef enum logic [1:0] {HS_ACTIVE, HS_FRONT, HS_SYNC, HS_BACK} h_state_t;
  typedef enum logic [1:0] {VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK} v_state_t;

  h_state_t   h_state;
  v_state_t   v_state;
  logic [3:0] div_cnt;
  logic [3:0] div_nxt;
  logic       h_wrap;
  logic       hsync_dec;
  logic       vsync_dec;
  logic       enable_dec;

  assign div_nxt = (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
  assign h_wrap  = pix_tick && (current_row == H_LAST);

  // pix_tick is registered from the next divider value so it stays low through reset even when PIX_DIV=1.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      div_cnt  <= 4'd0;
      pix_tick <= 1'b0;
    end else begin
      // NOTE: sequential state always uses <= so every register samples pre-edge values.
      div_cnt  <= div_nxt;
      pix_tick <= (div_nxt == DIV_LAST);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      h_state     <= HS_ACTIVE;
      current_row <= 10'd0;
    end else if (pix_tick) begin
      current_row <= (current_row == H_LAST) ? 10'd0 : current_row + 10'd1;
      case (h_state)
        HS_ACTIVE: if (current_row == H_ACT_LAST)  h_state <= HS_FRONT;
        HS_FRONT:  if (current_row == H_FP_LAST)   h_state <= HS_SYNC;
        HS_SYNC:   if (current_row == H_SYNC_LAST) h_state <= HS_BACK;
        HS_BACK:   if (current_row == H_LAST)      h_state <= HS_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      v_state      <= VS_ACTIVE;
      current_line <= 10'd0;
    end else if (h_wrap) begin
      current_line <= (current_line == V_LAST) ? 10'd0 : current_line + 10'd1;
      case (v_state)
        VS_ACTIVE: if (current_line == V_ACT_LAST)  v_state <= VS_FRONT;
        VS_FRONT:  if (current_line == V_FP_LAST)   v_state <= VS_SYNC;
        VS_SYNC:   if (current_line == V_SYNC_LAST) v_state <= VS_BACK;
        VS_BACK:   if (current_line == V_LAST)      v_state <= VS_ACTIVE;
      endcase
    end
  end

  // Start pulses land on the cycle the wrapped coordinates first appear.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b1;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && (current_line == V_LAST);
    end
  end

  assign hsync_dec  = (h_state != HS_SYNC);
  assign vsync_dec  = (v_state != VS_SYNC);
  assign enable_dec = (h_state == HS_ACTIVE) && (v_state == VS_ACTIVE);

`ifdef VGA_SYNC_ALIGN_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      enable <= 1'b0;
    end else if (pix_tick) begin
      hsync  <= hsync_dec;
      vsync  <= vsync_dec;
      enable <= enable_dec;
    end
  end
`else
  assign hsync  = hsync_dec;
  assign vsync  = vsync_dec;
  assign enable = enable_dec;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 VGA output path. Divides the system clock down to the pixel rate and scans horizontal and vertical counters. From these it produces the hsync/vsync pins, the active-video `enable` flag, and the `current_row`/`current_line` pixel coordinates. The pixel colouring stage consumes those signals every `clk_in` cycle to select `color_out`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines
- `PIX_DIV`, 4: `clk_in` cycles per pixel (100 MHz -> 25 MHz); legal range 1..16
- `clk_in`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `pix_tick`  out  1  one-`clk_in` pulse marking each pixel advance
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `enable`  out  1  high while the pixel is in the visible area
- `current_row`  out  10  horizontal pixel coordinate (x), 0..H_TOTAL-1
- `current_line`  out  10  vertical line coordinate (y), 0..V_TOTAL-1
- `line_start`  out  1  one-`clk_in` pulse when x becomes 0
- `frame_start`  out  1  one-`clk_in` pulse when x and y both become 0

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = 525.
- Prescaler `div_cnt`:
  - Counts 0..PIX_DIV-1 and wraps.
  - `pix_tick` is high on the cycle where `div_cnt == PIX_DIV-1`.
  - With PIX_DIV=1, `pix_tick` is constantly high after reset.
- Horizontal FSM, advanced only on `pix_tick`:
  - States HS_ACTIVE, HS_FRONT, HS_SYNC, HS_BACK.
  - Transitions occur when `current_row` reaches the last pixel of the phase: 639, 655, 751, 799.
  - HS_BACK at 799 wraps to HS_ACTIVE with x=0.
- Vertical FSM:
  - Same four states: VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK.
  - Advances only on a `pix_tick` where x wraps 799->0.
  - Boundary lines are 479, 489, 491, 524; 524 wraps to 0.
- Combinational decode of the registered state:
  - `hsync` = 0 iff state is HS_SYNC (x 656..751).
  - `vsync` = 0 iff state is VS_SYNC (y 490..491).
  - `enable` = (HS_ACTIVE && VS_ACTIVE).
- Counter arithmetic: 10-bit unsigned, no overflow possible. A compare-equal on the terminal value forces wrap, and never relies on natural rollover.
- `line_start` and `frame_start` are high for exactly one `clk_in`: the cycle after the wrapping `pix_tick`, coincident with the new coordinates.
- Reset values:
  - `div_cnt`=0, x=0, y=0.
  - Both FSMs in their ACTIVE state.
  - `hsync`=1, `vsync`=1, `enable`=1, `pix_tick`=0, `line_start`=0, `frame_start`=1 (the first frame starts out of reset).
- Reset asserted mid-frame: all state returns to the reset values on the next rising edge, regardless of `div_cnt`. No partial sync pulse is extended.

## Timing
- Outputs are registered, or are decodes of registered state only. There is no combinational path from any input to any output.
- Coordinates and `enable` change on the `clk_in` edge following a `pix_tick`, and then hold for PIX_DIV cycles.
- The colour stage registers `color_out` one `clk_in` later. With PIX_DIV>=2 this stays inside the same pixel slot.
- Line period = 800*PIX_DIV `clk_in` cycles. Frame period = 420000*PIX_DIV.
- The first `hsync` falling edge after reset comes 656*PIX_DIV cycles after reset deassertion.

## Configuration
- `VGA_SYNC_ALIGN_EN` defined:
  - `hsync`, `vsync` and `enable` pass through one extra register stage clocked on `pix_tick`. They lag the coordinates by exactly one pixel, matching a pixel pipeline one pixel deep.
  - The delay stage resets to `hsync`=1, `vsync`=1, `enable`=0.
- Not defined: sync and enable are aligned with the coordinates as described above.

## Test plan
- Reset release, PIX_DIV=4 -> `pix_tick` first high on cycle 3. x reads 0,0,0,0,1 over cycles 0..4. `frame_start` is high on cycle 0 only.
- Run one line -> `hsync` is low for exactly 384 cycles, starting 2624 cycles after reset. `enable` falls when x goes 639->640. `line_start` pulses at x=0, y=1.
- Run one frame -> `vsync` is low for exactly 2*800*4 = 6400 cycles, with y=490..491. `frame_start` pulses again at cycle 1680000. Both coordinates never exceed 799/524.
- Assert `rst_n`=0 for one cycle at x=700, y=491 (`vsync` low) -> next edge gives x=0, y=0, `vsync`=1, `hsync`=1. The timeline then repeats the first test exactly.
- PIX_DIV=1 -> `pix_tick` stays high. x increments every cycle. Line period is 800 cycles.
- `VGA_SYNC_ALIGN_EN` defined -> `hsync` falls one pixel (4 cycles) after x reaches 656. `enable` is 0 at x=0 of line 0 and becomes 1 at x=1.
